// File: rtl/sensor_pkg.sv
// Shared sensor-side definitions: default pixel width and row-select helpers.
package sensor_pkg;

  localparam int unsigned PIXEL_BITS = 8;
  // Widest row-select vector the helper functions accept.
  localparam int unsigned MAX_ROWS   = 32;

  // Width of an index into n items (never below 1 bit).
  function automatic int unsigned row_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [MAX_ROWS-1:0] v);
    return (v != '0) && ((v & (v - MAX_ROWS'(1))) == '0);
  endfunction

  // Index of the set bit of a one-hot vector (OR-reduction, result undefined otherwise).
  function automatic int unsigned onehot_to_index(input logic [MAX_ROWS-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_ROWS; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pixel_row_buffer.sv
// Two-entry ping-pong row store.
//   clk, reset       : clock, synchronous active-high reset
//   push, push_data  : write an entry (caller guarantees !full_c or a same-cycle pop)
//   pop              : retire the entry at the read pointer (caller guarantees !empty_c)
//   rd_data_c        : entry at the read pointer
//   count            : occupancy 0..2
//   full_c, empty_c  : occupancy flags
module pixel_row_buffer #(
  parameter int unsigned ENTRY_W = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rd_data_c,
  output logic [1:0]         count,
  output logic               full_c,
  output logic               empty_c
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;

  // Storage, pointers and occupancy; push into a full buffer overwrites the entry being popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full_c    = (count_q == 2'd2);
  assign empty_c   = (count_q == 2'd0);

endmodule

// File: rtl/pixel_readout.sv
// Sensor read-phase receiver: detects the selected row, captures its column bus after it
// settles, buffers up to two rows and streams pixels over valid/ready with frame/line markers.
//   clk, reset      : clock, synchronous active-high reset
//   p_row_select    : one-hot row select (all-zero when idle)
//   p_data          : column bus, pixel c at [c*PIXEL_BITS +: PIXEL_BITS]
//   out_*           : pixel stream (data, valid, ready, row, first, eol, last)
//   overflow, short_row, onehot_err : sticky error flags
module pixel_readout #(
  parameter int unsigned PIXEL_ARRAY_HEIGHT = 2,
  parameter int unsigned PIXEL_ARRAY_WIDTH  = 2,
  parameter int unsigned PIXEL_BITS         = sensor_pkg::PIXEL_BITS,
  parameter int unsigned SETTLE_CYCLES      = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [PIXEL_ARRAY_HEIGHT-1:0]             p_row_select,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]   p_data,
  output logic [PIXEL_BITS-1:0]                     out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [sensor_pkg::row_idx_w(PIXEL_ARRAY_HEIGHT)-1:0] out_row,
  output logic                                      out_first,
  output logic                                      out_eol,
  output logic                                      out_last,
  output logic                                      overflow,
  output logic                                      short_row,
  output logic                                      onehot_err
);

  import sensor_pkg::*;

  localparam int unsigned H  = PIXEL_ARRAY_HEIGHT;
  localparam int unsigned W  = PIXEL_ARRAY_WIDTH;
  localparam int unsigned PB = PIXEL_BITS;
  localparam int unsigned RW = row_idx_w(H);
  localparam int unsigned CW = row_idx_w(W);
  localparam int unsigned DW = W * PB;
  localparam int unsigned EW = DW + RW;
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 2);

  logic [H-1:0]  prev_sel_q;
  logic [SW-1:0] settle_q;
  logic          armed_q;
  logic [CW-1:0] col_q;
  logic          valid_q;
  logic          overflow_q;
  logic          short_row_q;
  logic          onehot_err_q;

  logic          sel_onehot_c;
  logic          sel_multi_c;
  logic          sel_changed_c;
  logic          new_row_c;
  logic          same_row_c;
  logic [SW-1:0] settle_eff_c;
  logic          capture_c;
  logic          short_c;

  logic          xfer_c;
  logic          last_col_c;
  logic          pop_c;
  logic          push_c;
  logic [EW-1:0] push_data_c;
  logic [EW-1:0] rd_data_c;
  logic [1:0]    buf_count;
  logic          full_c;
  logic          empty_c;
  logic [RW-1:0] row_c;
  logic [PB-1:0] pix_c;

  // Row detection: armed_q marks a selection that is still waiting for its capture.
  always_comb begin
    sel_onehot_c  = is_onehot(MAX_ROWS'(p_row_select));
    sel_multi_c   = (p_row_select != '0) && !sel_onehot_c;
    sel_changed_c = (p_row_select != prev_sel_q);
    new_row_c     = sel_onehot_c && sel_changed_c;
    same_row_c    = armed_q && !sel_changed_c;
    // The event cycle itself counts as settle step 0.
    settle_eff_c  = new_row_c ? '0 : settle_q;
    capture_c     = (new_row_c || same_row_c) && (settle_eff_c == SW'(SETTLE_CYCLES));
    short_c       = armed_q && sel_changed_c;
  end

  // Serializer handshake; a full buffer accepts a capture only alongside the final-pixel pop.
  always_comb begin
    last_col_c  = (col_q == CW'(W - 1));
    xfer_c      = valid_q && !empty_c && out_ready;
    pop_c       = xfer_c && last_col_c;
    push_c      = capture_c && (!full_c || pop_c);
    push_data_c = {RW'(onehot_to_index(MAX_ROWS'(p_row_select))), p_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sel_q   <= '0;
      settle_q     <= '0;
      armed_q      <= 1'b0;
      col_q        <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
      short_row_q  <= 1'b0;
      onehot_err_q <= 1'b0;
    end else begin
      prev_sel_q <= p_row_select;
      if (new_row_c || same_row_c) begin
        armed_q  <= !capture_c;
        settle_q <= capture_c ? settle_eff_c : settle_eff_c + SW'(1);
      end else begin
        armed_q  <= 1'b0;
      end
      if (xfer_c) col_q <= last_col_c ? '0 : col_q + CW'(1);
      // Mirrors the post-edge buffer occupancy.
      valid_q      <= push_c || (buf_count > 2'(pop_c));
      overflow_q   <= overflow_q   | (capture_c && !push_c);
      short_row_q  <= short_row_q  | short_c;
      onehot_err_q <= onehot_err_q | sel_multi_c;
    end
  end

  pixel_row_buffer #(
    .ENTRY_W (EW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .rd_data_c (rd_data_c),
    .count     (buf_count),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

  // Column select of the entry being read.
  always_comb begin
    pix_c = '0;
    for (int unsigned c = 0; c < W; c++) begin
      if (col_q == CW'(c)) pix_c = rd_data_c[c*PB +: PB];
    end
    row_c = rd_data_c[EW-1 -: RW];
  end

  // Outputs are forced to 0 while nothing is buffered.
  assign out_valid  = valid_q;
  assign out_data   = valid_q ? pix_c : '0;
  assign out_row    = valid_q ? row_c : '0;
  assign out_first  = valid_q && (row_c == '0) && (col_q == '0);
  assign out_eol    = valid_q && last_col_c;
  assign out_last   = valid_q && (row_c == RW'(H - 1)) && last_col_c;
  assign overflow   = overflow_q;
  assign short_row  = short_row_q;
  assign onehot_err = onehot_err_q;

endmodule

// File: doc/pixel_readout.md
Name: pixel_readout

Overview:
- Receiving end of the sensor read phase.
- Watches the one-hot row select driven by the sensor state controller and captures the selected row's column data bus once it has settled.
- Stores captured rows in a two-row ping-pong buffer.
- Streams pixels out one at a time over a valid/ready interface with frame and line markers. Sits between the pixel array and the downstream image sink.

Parameters:
- PIXEL_ARRAY_HEIGHT, 2, number of rows; width of p_row_select.
- PIXEL_ARRAY_WIDTH, 2, pixels per row.
- PIXEL_BITS, 8, bits per pixel value (matches dRamp width).
- SETTLE_CYCLES, 1, cycles a row must stay selected before capture (range 0..row_read_time-1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- p_row_select  in  PIXEL_ARRAY_HEIGHT  one-hot row select from the sensor controller; all-zero when not reading.
- p_data  in  PIXEL_ARRAY_WIDTH*PIXEL_BITS  column bus; pixel c occupies bits [c*PIXEL_BITS +: PIXEL_BITS]. May be X/Z when no row is selected.
- out_data  out  PIXEL_BITS  current pixel value.
- out_valid  out  1  out_data and the markers are valid.
- out_ready  in  1  sink accepts; a transfer occurs when out_valid & out_ready.
- out_row  out  max(1,$clog2(PIXEL_ARRAY_HEIGHT))  row index of the current pixel.
- out_first  out  1  row 0, column 0 (start of frame).
- out_eol  out  1  last column of a row.
- out_last  out  1  last row, last column (end of frame).
- overflow  out  1  sticky; a row was dropped because the buffer was full.
- short_row  out  1  sticky; a row was deselected before its capture.
- onehot_err  out  1  sticky; p_row_select had more than one bit set.

Behaviour:
- Reset: all outputs 0; buffer count 0; read and write pointers 0; column counter 0; prev_row_select 0; settle counter 0; sticky flags cleared.
- Row detection:
  - prev_row_select is registered every cycle.
  - A new-row event occurs when p_row_select is one-hot and differs from prev_row_select.
  - On that event the settle counter loads 0; it increments while the same row stays selected.
- Capture:
  - Occurs in the cycle where the same row is selected and settle counter == SETTLE_CYCLES.
  - Exactly one capture per selection; the counter saturates and is marked done until the next new-row event.
  - SETTLE_CYCLES=0 means capture on the event cycle itself.
- Short row: if the row changes or drops to zero before capture, set short_row and do not capture.
- Invalid select: p_row_select with popcount>1 is ignored as a row event and sets onehot_err. All-zero is idle.
- Buffer:
  - Two entries, each holding PIXEL_ARRAY_WIDTH*PIXEL_BITS bits plus the row index.
  - count ranges 0..2.
  - A capture writes the entry at wr_ptr when count<2, or when count==2 and the final pixel of the read entry transfers in the same cycle (simultaneous pop/push: count stays 2, no overflow).
  - Otherwise the row is dropped and overflow is set.
- Output:
  - out_valid = (count>0), registered.
  - out_data = entry[rd_ptr] column col; out_row = stored row index.
  - Transfer with col<W-1: col increments.
  - Transfer with col==W-1: col returns to 0, rd_ptr toggles, count decrements (unless a push occurs in the same cycle).
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Markers (combinational from stored row and col):
  - out_first = (row==0 && col==0).
  - out_eol = (col==W-1).
  - out_last = (row==H-1 && col==W-1).
- Latency: with the sink ready, the first pixel appears with out_valid=1 one cycle after the capture cycle.
- Reset mid-stream: the next cycle shows out_valid=0, all buffered rows are discarded, and flags are cleared.

Decomposition:
- Shared package (sensor_pkg): PIXEL_BITS, a row-index width function, a onehot_to_index function, and an is_onehot function.
- Sub-module pixel_row_buffer: two-entry ping-pong storage with push/pop/count/full/empty, parameterised on entry width.
- Top level: row detector, settle counter, column serializer, markers, sticky flags.

Test Plan:
(All with H=2, W=2, SETTLE=1.)
1. After reset, p_row_select=2'b01 held 5 cycles, p_data=16'hB2A1, out_ready=1 -> capture on the 2nd select cycle. Next cycle out_data=A1, out_first=1. Then B2 with out_eol=1. No flags.
2. Full frame: row0 16'hB2A1, then row1 16'h0403, each held 5 cycles -> stream A1,B2,03,04 with out_row 0,0,1,1; out_last=1 only on 04.
3. out_ready=0; rows 0, 1, 0 (next frame) presented -> third row dropped, overflow=1 and stays set. Then out_ready=1 -> exactly 4 pixels from the first two rows.
4. p_row_select=2'b01 for 1 cycle, then 2'b10 -> short_row=1, no row-0 output; row 1 is captured normally.
5. p_row_select=2'b11 -> onehot_err=1, no capture, out_valid stays 0.
6. Buffer full with out_ready=1 and the final pixel of the read entry transferring in the same cycle a capture occurs -> row accepted, overflow=0. Then assert reset while out_valid=1 -> next cycle out_valid=0 and all flags 0.
